bcd_timer: RTL and testbench
============================

BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, giving the number of CLK cycles per count tick; legal range 2..2^27-1.
REQ-002 SHALL have port CLK  input  1  system clock; one clock, all logic on posedge CLK.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to run or resume.
REQ-005 SHALL have port stop  input  1  single-cycle request to pause or abort.
REQ-006 SHALL have port load  input  1  single-cycle request to preset the count from load_val.
REQ-007 SHALL have port load_val  input  8  BCD preset; [7:4] is tens, [3:0] is ones.
REQ-008 SHALL have port mode  input  1  direction: 0 = count down, 1 = count up.
REQ-009 SHALL have port num  output  8  registered BCD count; [3:0] ones, [7:4] tens; drives the seven-segment display stage.
REQ-010 SHALL have port idle  output  1  registered; 1 blanks the display stage.
REQ-011 SHALL have port done  output  1  registered single-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE and DONE, with a 27-bit prescaler and a latched direction bit.
REQ-013 idle SHALL be 1 exactly while in IDLE and 0 in all other states, registered so that it changes together with the state.
REQ-014 load SHALL be honoured only in IDLE or PAUSE, and only when both nibbles of load_val are <= 9.
  - Honoured load: num <= load_val on the next edge; state unchanged.
  - Any other load SHALL be ignored.
REQ-015 IDLE or PAUSE with start=1 and stop=0 SHALL enter RUN and latch mode.
  - From IDLE: prescaler cleared.
  - From PAUSE: prescaler retained.
REQ-016 Exception to REQ-015: if num==8'h00 with mode=0, or num==8'h99 with mode=1, start SHALL go directly to DONE and pulse done.
REQ-017 In RUN, the prescaler SHALL increment each cycle; on reaching TICK_DIV-1 it SHALL wrap to 0 on the next edge, which is a tick.
REQ-018 Tick, up direction: ones SHALL increment; ones 9 -> 0 with carry into tens.
REQ-019 Tick, down direction: ones SHALL decrement; ones 0 -> 9 with borrow from tens.
REQ-019a On a tick, num SHALL always remain valid BCD.
REQ-020 A tick that produces 8'h00 (down) or 8'h99 (up) SHALL update num and enter DONE on the same edge, with done=1 for exactly that one following cycle.
REQ-021 In RUN, stop=1 SHALL enter PAUSE; prescaler and num are held.
REQ-021a stop SHALL take priority over a coincident tick: no num update on that edge.
REQ-022 In PAUSE, stop=1 SHALL enter IDLE and clear num to 8'h00.
REQ-023 start and stop asserted together SHALL be treated as stop alone.
REQ-024 In DONE, num SHALL be held; start=1 or stop=1 SHALL enter IDLE with num retained.
REQ-025 start in RUN, and load outside IDLE/PAUSE, SHALL have no effect.
REQ-026 Changes on mode SHALL be ignored except at entry to RUN.
REQ-027 done SHALL never be asserted for two consecutive cycles.

Reset
REQ-028 RST_N=0 sampled at a posedge SHALL, on that edge, set state=IDLE, num=8'h00, idle=1, done=0, prescaler=0 and direction=0, overriding all other inputs.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort with no done pulse; state after release is identical to power-up.
REQ-030 Outputs SHALL be defined from the first reset edge; no initial-block reliance.

Verification (TICK_DIV=4)
REQ-031 Load 8'h12, mode=0, start -> num 12,11,10,09,...,01,00 every 4 cycles; done one cycle on reaching 00; idle=0 throughout RUN and DONE.
REQ-032 Load 8'h97, mode=1, start -> num 98, 99, then DONE; done pulses once; num holds 99 until start, then idle=1 with num=99.
REQ-033 Load 8'h3A -> ignored (num unchanged); load 8'h20 during RUN -> ignored; load 8'h20 in PAUSE -> num=20.
REQ-034 RUN at 8'h10, down, stop asserted on the tick cycle -> PAUSE with num=10; start -> resumes, next tick after the remaining prescaler count gives 09; stop, stop -> IDLE, num=00, idle=1.
REQ-035 start with num=00, mode=0 -> DONE next cycle, done=1 for one cycle; start+stop together in IDLE -> stays IDLE.
REQ-036 RST_N=0 for one edge mid-RUN at num=45 -> num=00, idle=1, done=0 next cycle; counting does not resume without start.

Source files
------------

// File: rtl/bcd_timer.sv
// Two-digit BCD count-up/count-down timer with a prescaled tick,
// run/pause/done control and a single-cycle completion pulse.
module bcd_timer #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       mode,
    output logic [7:0] num,
    output logic       idle,
    output logic       done
);

    localparam int unsigned PRESC_W   = 27;
    localparam int unsigned NUM_W     = 8;
    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               dir_q, dir_d;
    logic               idle_q, idle_d;
    logic               done_q, done_d;

    logic               load_ok_c;
    logic               start_end_c;
    logic [NUM_W-1:0]   num_up_c;
    logic [NUM_W-1:0]   num_dn_c;
    logic [NUM_W-1:0]   num_tick_c;
    logic               tick_end_c;

    // Preset legality, start-at-terminal detection and BCD step values
    always_comb begin
        load_ok_c   = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
        start_end_c = mode ? (num_q == 8'h99) : (num_q == 8'h00);

        num_up_c = num_q;
        if (num_q[3:0] >= 4'd9) begin
            num_up_c[3:0] = 4'd0;
            num_up_c[7:4] = (num_q[7:4] >= 4'd9) ? 4'd0 : num_q[7:4] + 4'd1;
        end else begin
            num_up_c[3:0] = num_q[3:0] + 4'd1;
        end

        num_dn_c = num_q;
        if (num_q[3:0] == 4'd0) begin
            num_dn_c[3:0] = 4'd9;
            num_dn_c[7:4] = (num_q[7:4] == 4'd0) ? 4'd9 : num_q[7:4] - 4'd1;
        end else begin
            num_dn_c[3:0] = num_q[3:0] - 4'd1;
        end

        num_tick_c = dir_q ? num_up_c : num_dn_c;
        tick_end_c = dir_q ? (num_tick_c == 8'h99) : (num_tick_c == 8'h00);
    end

    // Next-state, count, prescaler and registered-output logic
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_PAUSE: begin
                if (stop) begin
                    if (state_q == S_PAUSE) begin
                        state_d = S_IDLE;
                        num_d   = 8'h00;
                    end
                end else if (start) begin
                    dir_d = mode;
                    if (start_end_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        if (state_q == S_IDLE) begin
                            presc_d = '0;
                        end
                    end
                end else if (load && load_ok_c) begin
                    num_d = load_val;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_PAUSE;
                end else if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    num_d   = num_tick_c;
                    if (tick_end_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            S_DONE: begin
                if (start || stop) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        idle_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            num_q   <= 8'h00;
            presc_q <= '0;
            dir_q   <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
        end
    end

    assign num  = num_q;
    assign idle = idle_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Bench for bcd_timer: decimal-value reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bcd_timer;

    localparam int unsigned TICK_DIV = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       start;
    logic       stop;
    logic       load;
    logic [7:0] load_val;
    logic       mode;
    logic [7:0] num;
    logic       idle;
    logic       done;

    int checks   = 0;
    int failures = 0;

    bcd_timer #(.TICK_DIV(TICK_DIV)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (start),
        .stop    (stop),
        .load    (load),
        .load_val(load_val),
        .mode    (mode),
        .num     (num),
        .idle    (idle),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    // Reference model: count held as a decimal integer 0..99
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_state = M_IDLE;
    int m_val   = 0;
    int m_ticks = 0;
    bit m_up    = 1'b0;
    bit m_done  = 1'b0;
    bit m_valid = 1'b0;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(posedge CLK) begin
        int tens;
        int ones;
        tens = int'(load_val[7:4]);
        ones = int'(load_val[3:0]);
        if (!RST_N) begin
            m_state = M_IDLE;
            m_val   = 0;
            m_ticks = 0;
            m_up    = 1'b0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 1'b0;
            case (m_state)
                M_IDLE, M_PAUSE: begin
                    if (stop) begin
                        if (m_state == M_PAUSE) begin
                            m_state = M_IDLE;
                            m_val   = 0;
                        end
                    end else if (start) begin
                        m_up = mode;
                        if ((mode && m_val == 99) || (!mode && m_val == 0)) begin
                            m_state = M_DONE;
                            m_done  = 1'b1;
                        end else begin
                            if (m_state == M_IDLE) m_ticks = 0;
                            m_state = M_RUN;
                        end
                    end else if (load && tens < 10 && ones < 10) begin
                        m_val = tens * 10 + ones;
                    end
                end
                M_RUN: begin
                    if (stop) begin
                        m_state = M_PAUSE;
                    end else if (m_ticks == TICK_DIV - 1) begin
                        m_ticks = 0;
                        m_val   = m_up ? m_val + 1 : m_val - 1;
                        if (m_val == (m_up ? 99 : 0)) begin
                            m_state = M_DONE;
                            m_done  = 1'b1;
                        end
                    end else begin
                        m_ticks = m_ticks + 1;
                    end
                end
                default: begin
                    if (start || stop) m_state = M_IDLE;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled mid-period
    logic prev_done = 1'b0;
    always @(negedge CLK) begin
        if (m_valid) begin
            checks++;
            if (num !== to_bcd(m_val)) begin
                failures++;
                $display("FAIL model_num t=%0t got=%h exp=%h", $time, num, to_bcd(m_val));
            end
            checks++;
            if (idle !== (m_state == M_IDLE)) begin
                failures++;
                $display("FAIL model_idle t=%0t got=%b exp=%b", $time, idle, (m_state == M_IDLE));
            end
            checks++;
            if (done !== m_done) begin
                failures++;
                $display("FAIL model_done t=%0t got=%b exp=%b", $time, done, m_done);
            end
            checks++;
            if (done === 1'b1 && prev_done === 1'b1) begin
                failures++;
                $display("FAIL done_twice t=%0t got=1 exp=0", $time);
            end
            prev_done = done;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start(input logic m);
        mode = m; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s got=no_done exp=done_within_%0d", name, limit);
        end
    endtask

    initial begin
        RST_N = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = 8'h00; mode = 1'b0;
        cyc(2);
        chk("reset_num", num, 8'h00);
        chk("reset_idle", {7'd0, idle}, 8'h01);
        chk("reset_done", {7'd0, done}, 8'h00);
        RST_N = 1'b1;
        cyc(1);

        // Count down from 12 to 00
        do_load(8'h12);
        chk("load12", num, 8'h12);
        do_start(1'b0);
        chk("run_idle", {7'd0, idle}, 8'h00);
        cyc(4);
        chk("first_tick", num, 8'h11);
        wait_done("down_done", 100);
        chk("down_end", num, 8'h00);
        cyc(1);
        chk("down_done_drop", {7'd0, done}, 8'h00);
        do_start(1'b0);
        chk("down_exit_idle", {7'd0, idle}, 8'h01);

        // Count up from 97 to 99
        do_load(8'h97);
        do_start(1'b1);
        wait_done("up_done", 40);
        chk("up_end", num, 8'h99);
        cyc(3);
        chk("up_hold", num, 8'h99);
        chk("up_hold_idle", {7'd0, idle}, 8'h00);
        do_start(1'b0);
        chk("up_exit_idle", {7'd0, idle}, 8'h01);
        chk("up_exit_num", num, 8'h99);

        // Illegal and misplaced loads
        do_load(8'h3A);
        chk("bad_load", num, 8'h99);
        do_start(1'b0);
        do_load(8'h20);
        chk("run_load", num, 8'h99);
        do_stop();
        do_load(8'h20);
        chk("pause_load", num, 8'h20);
        do_stop();
        chk("pause_stop_num", num, 8'h00);

        // Stop coinciding with the tick, then resume
        do_load(8'h10);
        do_start(1'b0);
        cyc(3);
        do_stop();
        chk("stop_on_tick", num, 8'h10);
        do_start(1'b0);
        cyc(1);
        chk("resume_tick", num, 8'h09);
        do_stop();
        do_stop();
        chk("abort_num", num, 8'h00);
        chk("abort_idle", {7'd0, idle}, 8'h01);

        // Start at terminal value, then start+stop together
        do_start(1'b0);
        chk("imm_done", {7'd0, done}, 8'h01);
        cyc(1);
        chk("imm_done_drop", {7'd0, done}, 8'h00);
        do_stop();
        do_load(8'h05);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("both_idle", {7'd0, idle}, 8'h01);
        chk("both_num", num, 8'h05);

        // Reset mid-run
        do_load(8'h45);
        do_start(1'b0);
        cyc(2);
        RST_N = 1'b0;
        cyc(1);
        RST_N = 1'b1;
        chk("rst_num", num, 8'h00);
        chk("rst_idle", {7'd0, idle}, 8'h01);
        chk("rst_done", {7'd0, done}, 8'h00);
        cyc(10);
        chk("rst_stays", num, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
